// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the single-byte SPI master.
//   - MODE0..MODE3 : SPI mode encodings, bit1 = CPOL, bit0 = CPHA
//   - spi_state_e  : master FSM states
//   - DEFAULT_DATA_W : default frame width in bits
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   SCLK divider for the SPI master. While run_i is high the divider counts
//   CLK_DIV clk cycles per tick; while toggle_en_i is also high every tick
//   toggles sclk and is reported as a leading or trailing edge strobe.
//   Outside toggle_en_i, sclk is forced to cpol_i.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   run_i        in   divider counting enable (frame in progress)
//   toggle_en_i  in   sclk toggle enable (data phase)
//   cpol_i       in   idle level of sclk
//   tick_o       out  end of a CLK_DIV-cycle period (combinational strobe)
//   lead_edge_o  out  this tick registers a leading sclk edge
//   trail_edge_o out  this tick registers a trailing sclk edge
//   half_cnt_o   out  number of sclk toggles already made in the data phase
//   sclk_o       out  SPI clock (registered)
// -----------------------------------------------------------------------------
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run_i,
   input  logic                          toggle_en_i,
   input  logic                          cpol_i,
   output logic                          tick_o,
   output logic                          lead_edge_o,
   output logic                          trail_edge_o,
   output logic [$clog2(2*DATA_W)-1:0]   half_cnt_o,
   output logic                          sclk_o
);

   localparam int HALF_W = $clog2(2*DATA_W);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0]        div_cnt_q,  div_cnt_d;
   logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
   logic              sclk_q,     sclk_d;
   logic              tick;

   assign tick = run_i && (div_cnt_q == DIV_LAST);

   always_comb begin
      div_cnt_d  = 8'd0;
      half_cnt_d = '0;
      sclk_d     = cpol_i;
      if (run_i) begin
         div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
      end
      if (toggle_en_i) begin
         half_cnt_d = tick ? half_cnt_q + 1'b1 : half_cnt_q;
         sclk_d     = tick ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_q  <= 8'd0;
         half_cnt_q <= '0;
         sclk_q     <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         half_cnt_q <= half_cnt_d;
         sclk_q     <= sclk_d;
      end
   end

   // Toggle number half_cnt_q+1 is about to happen: odd numbers lead.
   assign tick_o       = tick;
   assign lead_edge_o  = toggle_en_i && tick && !half_cnt_q[0];
   assign trail_edge_o = toggle_en_i && tick &&  half_cnt_q[0];
   assign half_cnt_o   = half_cnt_q;
   assign sclk_o       = sclk_q;

endmodule : spi_clk_gen

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-frame SPI master for one slave. Sends tx_data LSB first on mosi
//   and shifts miso in MSB first. All four SPI modes, SCLK half-period of
//   CLK_DIV clk cycles. Frame: IDLE -> SETUP -> XFER -> HOLD -> IDLE(done).
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   mode     in   {CPOL, CPHA}, sampled when start is accepted
//   start    in   transfer request, accepted while busy = 0
//   tx_data  in   frame to send, latched when start is accepted
//   busy     out  frame in progress
//   done     out  one-cycle completion pulse
//   rx_data  out  received frame, updated with done
//   sclk     out  SPI clock
//   cs       out  chip select, active low
//   mosi     out  master-out data
//   miso     in   master-in data (sclk-synchronous)
// -----------------------------------------------------------------------------
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   localparam int HALF_W = $clog2(2*DATA_W);
   localparam int BIT_W  = $clog2(DATA_W+1);
   localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2*DATA_W - 1);
   localparam logic [BIT_W-1:0]  ALL_BITS  = BIT_W'(DATA_W);

   spi_state_e        state_q,   state_d;
   logic              cpol_q,    cpol_d;
   logic              cpha_q,    cpha_d;
   logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
   logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              mosi_q,    mosi_d;
   logic              cs_q,      cs_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;

   logic              tick;
   logic              lead_edge;
   logic              trail_edge;
   logic [HALF_W-1:0] half_cnt;
   logic              sclk_int;
   logic              cpol_sel;

   // In IDLE sclk tracks the live CPOL request; during a frame the latched one.
   assign cpol_sel = (state_q == IDLE) ? mode[1] : cpol_q;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV),
      .DATA_W  (DATA_W)
   ) u_clk_gen (
      .clk          (clk),
      .reset        (reset),
      .run_i        (state_q != IDLE),
      .toggle_en_i  (state_q == XFER),
      .cpol_i       (cpol_sel),
      .tick_o       (tick),
      .lead_edge_o  (lead_edge),
      .trail_edge_o (trail_edge),
      .half_cnt_o   (half_cnt),
      .sclk_o       (sclk_int)
   );

   always_comb begin
      state_d   = state_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      bit_cnt_d = bit_cnt_q;
      mosi_d    = mosi_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SETUP;
               cpol_d    = mode[1];
               cpha_d    = mode[0];
               tx_sr_d   = tx_data;
               rx_sr_d   = '0;
               bit_cnt_d = '0;
               // CPHA=0 slaves sample on the first edge, so bit 0 must be
               // on the wire for the whole setup period.
               if (!mode[0]) begin
                  mosi_d = tx_data[0];
               end
            end
         end

         SETUP: begin
            if (tick) begin
               state_d = XFER;
            end
         end

         XFER: begin
            if (lead_edge) begin
               if (!cpha_q) begin
                  rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end else begin
                  mosi_d  = tx_sr_q[0];
                  tx_sr_d = tx_sr_q >> 1;
               end
            end
            if (trail_edge) begin
               if (cpha_q) begin
                  rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end else if (bit_cnt_q != ALL_BITS) begin
                  // tx_sr_q[0] is the bit already on the wire.
                  mosi_d  = tx_sr_q[1];
                  tx_sr_d = tx_sr_q >> 1;
               end
               if (half_cnt == LAST_HALF) begin
                  state_d = HOLD;
               end
            end
         end

         HOLD: begin
            if (tick) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               rx_data_d = rx_sr_q;
            end
         end

         default: state_d = IDLE;
      endcase

      cs_d   = (state_d == IDLE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         bit_cnt_q <= '0;
         mosi_q    <= 1'b0;
         cs_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         bit_cnt_q <= bit_cnt_d;
         mosi_q    <= mosi_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sclk    = sclk_int;
   assign cs      = cs_q;
   assign mosi    = mosi_q;

endmodule : spi_master

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Self-checking bench for spi_master: a table of full frames against a
//   model slave (all four modes), plus hand-written sequences for
//   back-to-back frames, mid-frame input disturbance, mid-frame reset and
//   the CLK_DIV=1 / CLK_DIV=5 loopback latency cases.
// -----------------------------------------------------------------------------
module tb_spi_master;
   import spi_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [1:0] mode;
   logic       start, start1, start5;
   logic [7:0] tx_data;

   logic       busy, done, sclk, cs, mosi, miso;
   logic [7:0] rx_data;
   logic       busy1, done1, sclk1, cs1, mosi1, miso1;
   logic [7:0] rx_data1;
   logic       busy5, done5, sclk5, cs5, mosi5, miso5;
   logic [7:0] rx_data5;

   spi_master #(.CLK_DIV(2), .DATA_W(8)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .start(start), .tx_data(tx_data),
      .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .cs(cs),
      .mosi(mosi), .miso(miso)
   );

   spi_master #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .mode(mode), .start(start1), .tx_data(tx_data),
      .busy(busy1), .done(done1), .rx_data(rx_data1), .sclk(sclk1), .cs(cs1),
      .mosi(mosi1), .miso(miso1)
   );

   spi_master #(.CLK_DIV(5), .DATA_W(8)) u_dut5 (
      .clk(clk), .reset(reset), .mode(mode), .start(start5), .tx_data(tx_data),
      .busy(busy5), .done(done5), .rx_data(rx_data5), .sclk(sclk5), .cs(cs5),
      .mosi(mosi5), .miso(miso5)
   );

   assign miso1 = mosi1;
   assign miso5 = mosi5;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // ---------------- model slave ----------------
   // Launches its byte MSB first on the launch edge and inverts miso right
   // after each sample edge, so a master sampling on the wrong edge reads
   // inverted bits. It also records mosi on each sample edge.
   logic       cur_cpol = 1'b0;
   logic       cur_cpha = 1'b0;
   logic [7:0] sl_byte  = 8'h00;
   logic       slave_miso = 1'b0;
   logic [7:0] mosi_cap = 8'h00;
   int         sl_idx   = 7;
   int         cap_idx  = 0;
   int         rise_cnt = 0;

   assign miso = slave_miso;

   always @(negedge cs) begin
      cap_idx  = 0;
      rise_cnt = 0;
      mosi_cap = 8'h00;
      sl_idx   = 7;
      if (!cur_cpha) begin
         slave_miso = sl_byte[7];
         sl_idx     = 6;
      end
   end

   always @(sclk) begin
      if (cs === 1'b0) begin
         if ((sclk != cur_cpol) ^ cur_cpha) begin
            if (cap_idx < 8) mosi_cap[cap_idx] = mosi;
            cap_idx++;
            slave_miso = ~slave_miso;
         end else if (sl_idx >= 0) begin
            slave_miso = sl_byte[sl_idx];
            sl_idx--;
         end
      end
   end

   always @(posedge sclk) if (cs === 1'b0) rise_cnt++;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic wait_done(input int limit, output logic seen, output logic prev_cs);
      seen    = 1'b0;
      prev_cs = cs;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         prev_cs = cs;
      end
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [7:0] tx;
      logic [7:0] slave;
      logic [7:0] exp_rx;
      int         exp_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input string tag);
      int   t0;
      logic seen, pcs;
      cur_cpol = v.mode[1];
      cur_cpha = v.mode[0];
      sl_byte  = v.slave;
      @(negedge clk);
      mode = v.mode;
      @(negedge clk);
      check({tag, " sclk idle before"}, 32'(sclk), 32'(v.mode[1]));
      tx_data = v.tx;
      start   = 1'b1;
      t0      = cyc;
      @(negedge clk);
      start   = 1'b0;
      tx_data = ~v.tx;
      wait_done(120, seen, pcs);
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, 32'(cyc - t0), 32'(v.exp_lat));
      check({tag, " rx_data"}, 32'(rx_data), 32'(v.exp_rx));
      check({tag, " mosi bits"}, 32'(mosi_cap), 32'(v.tx));
      check({tag, " sclk rises"}, 32'(rise_cnt), 32'd8);
      check({tag, " cs/busy/sclk at done"}, {29'd0, cs, busy, sclk}, {29'd0, 1'b1, 1'b0, v.mode[1]});
      check({tag, " cs low before done"}, 32'(pcs), 32'd0);
      @(negedge clk);
      check({tag, " done one cycle"}, 32'(done), 32'd0);
   endtask

   task automatic loop_frame(input int which, input logic [7:0] tx, input logic [7:0] exp_rx,
                             input int exp_lat, input string tag);
      int   t0;
      logic seen;
      seen = 1'b0;
      mode = MODE0;
      @(negedge clk);
      tx_data = tx;
      if (which == 1) start1 = 1'b1;
      else            start5 = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start1 = 1'b0;
      start5 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((which == 1 && done1 === 1'b1) || (which == 5 && done5 === 1'b1)) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, 32'(cyc - t0), 32'(exp_lat));
      check({tag, " rx_data"}, 32'((which == 1) ? rx_data1 : rx_data5), 32'(exp_rx));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int   t1, d0;
      logic seen, pcs;

      vecs[0] = '{mode: MODE0, tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C, exp_lat: 37};
      vecs[1] = '{mode: MODE1, tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_lat: 37};
      vecs[2] = '{mode: MODE2, tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_lat: 37};
      vecs[3] = '{mode: MODE3, tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_lat: 37};
      vecs[4] = '{mode: MODE0, tx: 8'h5A, slave: 8'hC3, exp_rx: 8'hC3, exp_lat: 37};

      mode = MODE0; start = 1'b0; start1 = 1'b0; start5 = 1'b0; tx_data = 8'h00;
      reset = 1'b1;
      #1 reset = 1'b0;
      #20;
      check("reset cs/sclk/mosi/busy/done", {27'd0, cs, sclk, mosi, busy, done}, 32'b10000);
      check("reset rx_data", 32'(rx_data), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Table of full frames.
      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back frames: second start issued in the done cycle.
      cur_cpol = 1'b0; cur_cpha = 1'b0; sl_byte = 8'h96;
      mode = MODE0;
      @(negedge clk);
      tx_data = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(120, seen, pcs);
      check("b2b first done", 32'(seen), 32'd1);
      check("b2b first rx", 32'(rx_data), 32'h96);
      check("b2b first mosi", 32'(mosi_cap), 32'h01);
      check("b2b cs at done / before", {30'd0, cs, pcs}, 32'b10);
      t1 = cyc;
      sl_byte = 8'h5A; tx_data = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b cs/busy after accept", {30'd0, cs, busy}, 32'b01);
      wait_done(120, seen, pcs);
      check("b2b second done", 32'(seen), 32'd1);
      check("b2b done spacing", 32'(cyc - t1), 32'd37);
      check("b2b second rx", 32'(rx_data), 32'h5A);
      check("b2b second mosi", 32'(mosi_cap), 32'hFF);

      // Start pulses and tx_data/mode changes while busy.
      repeat (3) @(negedge clk);
      cur_cpol = 1'b0; cur_cpha = 1'b0; sl_byte = 8'h3C;
      mode = MODE0;
      d0 = done_cnt;
      @(negedge clk);
      tx_data = 8'hA5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start   = i[0];
         tx_data = 8'(i * 37);
         mode    = 2'(i);
      end
      start = 1'b0;
      mode  = MODE0;
      wait_done(60, seen, pcs);
      check("disturb done", 32'(seen), 32'd1);
      check("disturb rx", 32'(rx_data), 32'h3C);
      check("disturb mosi", 32'(mosi_cap), 32'hA5);
      repeat (60) @(negedge clk);
      check("disturb done count", 32'(done_cnt - d0), 32'd1);
      check("disturb idle busy", 32'(busy), 32'd0);

      // Asynchronous reset in cycle 15 of a CPOL=1 frame.
      cur_cpol = 1'b1; cur_cpha = 1'b0; sl_byte = 8'hE7;
      mode = MODE2;
      repeat (2) @(negedge clk);
      tx_data = 8'h3A; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("pre-reset sclk high", 32'(sclk), 32'd1);
      d0 = done_cnt;
      #2 reset = 1'b0;
      #1;
      check("async reset cs/sclk/busy/done", {28'd0, cs, sclk, busy, done}, 32'b1000);
      check("async reset rx_data", 32'(rx_data), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("no done after reset", 32'(done_cnt - d0), 32'd0);
      check("rx_data after reset", 32'(rx_data), 32'd0);
      run_vec(vecs[2], "post-reset");

      // Loopback with other dividers.
      loop_frame(1, 8'hC3, 8'hC3, 19, "div1 C3");
      loop_frame(1, 8'h1D, 8'hB8, 19, "div1 1D");
      loop_frame(5, 8'hC3, 8'hC3, 91, "div5 C3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_spi_master
